noise_channel: RTL and testbench



---
 rtl/sound_pkg.sv | 34 +++
 rtl/noise_channel_if.sv | 65 ++++++
 rtl/volume_envelope.sv | 53 +++++
 rtl/noise_channel.sv | 119 +++++++++++
 tb/tb_noise_channel.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/sound_pkg.sv
// ============================================================================
// Module : sound_pkg
// Brief  : Shared sound constants, types and the noise-period helper.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package sound_pkg;

  localparam int NOISE_TIMER_W = 18;

  // Noise divisor table, indexed by the 3-bit ratio code r
  localparam logic [4:0] NOISE_DIV [8] = '{5'd2, 5'd4, 5'd8, 5'd12,
                                           5'd16, 5'd20, 5'd24, 5'd28};

  localparam logic [14:0] LFSR_SEED    = 15'h7FFF;
  localparam int          LENGTH_MAX_6 = 64;
  localparam logic [3:0]  VOL_MAX      = 4'd15;

  typedef logic [3:0] volume_t;

  // Period in base ticks; callers never use it for shifts of 14 or 15
  function automatic logic [NOISE_TIMER_W-1:0] noise_period(
    input logic [2:0] ratio,
    input logic [3:0] shift
  );
    logic [NOISE_TIMER_W-1:0] base;
    base = NOISE_TIMER_W'(NOISE_DIV[ratio]);
    return base << shift;
  endfunction

endpackage

`default_nettype wire

// File: rtl/noise_channel_if.sv
// ============================================================================
// Module : noise_channel_if
// Brief  : Control fields, strobes and outputs of sound channel 4.
//          CH4_LFSR_OBSERVE_EN adds the lfsr_state debug output.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface noise_channel_if;
  import sound_pkg::*;

  logic        base_tick;
  logic        length_tick;
  logic        env_tick;
  logic        initialize;
  logic [5:0]  length_data;
  volume_t     initial_volume;
  logic        envelope_increasing;
  logic [2:0]  num_envelope_sweeps;
  logic [3:0]  shift_clock_freq_data;
  logic        counter_width;
  logic [2:0]  freq_dividing_ratio;
  logic        dont_loop;
  volume_t     level;
  logic        on_flag;

`ifdef CH4_LFSR_OBSERVE_EN
  logic [14:0] lfsr_state;

  modport master (
    output base_tick, length_tick, env_tick, initialize, length_data,
           initial_volume, envelope_increasing, num_envelope_sweeps,
           shift_clock_freq_data, counter_width, freq_dividing_ratio,
           dont_loop,
    input  level, on_flag, lfsr_state
  );

  modport slave (
    input  base_tick, length_tick, env_tick, initialize, length_data,
           initial_volume, envelope_increasing, num_envelope_sweeps,
           shift_clock_freq_data, counter_width, freq_dividing_ratio,
           dont_loop,
    output level, on_flag, lfsr_state
  );
`else
  modport master (
    output base_tick, length_tick, env_tick, initialize, length_data,
           initial_volume, envelope_increasing, num_envelope_sweeps,
           shift_clock_freq_data, counter_width, freq_dividing_ratio,
           dont_loop,
    input  level, on_flag
  );

  modport slave (
    input  base_tick, length_tick, env_tick, initialize, length_data,
           initial_volume, envelope_increasing, num_envelope_sweeps,
           shift_clock_freq_data, counter_width, freq_dividing_ratio,
           dont_loop,
    output level, on_flag
  );
`endif

endinterface

`default_nettype wire

// File: rtl/volume_envelope.sv
// ============================================================================
// Module : volume_envelope
// Brief  : Volume register with periodic saturating up/down stepping.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module volume_envelope
  import sound_pkg::*;
(
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic       i_trigger,
  input  wire logic       i_env_tick,
  input  wire volume_t    i_initial_volume,
  input  wire logic       i_increasing,
  input  wire logic [2:0] i_sweeps,
  output volume_t         o_volume
);

  volume_t    r_volume;
  logic [2:0] r_step_cnt;
  logic       w_step_due;
  logic       w_at_limit;

  // A zero counter (never loaded) is treated as already expired
  assign w_step_due = (r_step_cnt <= 3'd1);
  assign w_at_limit = i_increasing ? (r_volume == VOL_MAX) : (r_volume == 4'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_volume   <= 4'd0;
      r_step_cnt <= 3'd0;
    end else if (i_trigger) begin
      r_volume   <= i_initial_volume;
      r_step_cnt <= i_sweeps;
    end else if (i_env_tick && (i_sweeps != 3'd0)) begin
      if (w_step_due) begin
        r_step_cnt <= i_sweeps;
        if (!w_at_limit) begin
          r_volume <= i_increasing ? (r_volume + 4'd1) : (r_volume - 4'd1);
        end
      end else begin
        r_step_cnt <= r_step_cnt - 3'd1;
      end
    end
  end

  assign o_volume = r_volume;

endmodule

`default_nettype wire

// File: rtl/noise_channel.sv
// ============================================================================
// Module : noise_channel
// Brief  : Sound channel 4 - LFSR noise with volume envelope and length
//          counter. CH4_LFSR_OBSERVE_EN exposes a registered LFSR copy.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module noise_channel
  import sound_pkg::*;
#(
  parameter int LFSR_W  = 15,
  parameter int TIMER_W = 18
) (
  input wire logic         ac97_bitclk,
  input wire logic         reset,
  noise_channel_if.slave   bus
);

  logic               r_init_d;
  logic               w_trigger;
  logic               w_dac_on;
  logic [TIMER_W-1:0] r_timer;
  logic [TIMER_W-1:0] w_period;
  logic               w_frozen;
  logic               w_expire;
  logic [LFSR_W-1:0]  r_lfsr;
  logic [LFSR_W-1:0]  w_lfsr_next;
  logic               w_fb;
  logic [6:0]         r_length;
  logic               r_on;
  volume_t            r_level;
  volume_t            w_volume;

  assign w_trigger = bus.initialize & ~r_init_d;
  assign w_dac_on  = (bus.initial_volume != 4'd0) | bus.envelope_increasing;

  always_ff @(posedge ac97_bitclk or posedge reset) begin
    if (reset) r_init_d <= 1'b0;
    else       r_init_d <= bus.initialize;
  end

  // Shift values 14 and 15 stop the timer entirely
  assign w_period = TIMER_W'(noise_period(bus.freq_dividing_ratio,
                                          bus.shift_clock_freq_data));
  assign w_frozen = (bus.shift_clock_freq_data[3:1] == 3'b111);
  assign w_expire = (r_timer <= TIMER_W'(1));

  assign w_fb = r_lfsr[0] ^ r_lfsr[1];

  always_comb begin
    w_lfsr_next = {w_fb, r_lfsr[LFSR_W-1:1]};
    if (bus.counter_width) w_lfsr_next[6] = w_fb;
  end

  always_ff @(posedge ac97_bitclk or posedge reset) begin
    if (reset) begin
      r_timer <= '0;
      r_lfsr  <= LFSR_SEED;
    end else if (w_trigger) begin
      r_timer <= w_period;
      r_lfsr  <= LFSR_SEED;
    end else if (bus.base_tick && !w_frozen) begin
      if (w_expire) begin
        r_timer <= w_period;
        r_lfsr  <= w_lfsr_next;
      end else begin
        r_timer <= r_timer - TIMER_W'(1);
      end
    end
  end

  // Length counter owns on_flag after the trigger decides its start value
  always_ff @(posedge ac97_bitclk or posedge reset) begin
    if (reset) begin
      r_length <= 7'd0;
      r_on     <= 1'b0;
    end else if (w_trigger) begin
      r_length <= 7'(LENGTH_MAX_6) - {1'b0, bus.length_data};
      r_on     <= w_dac_on;
    end else if (bus.length_tick && bus.dont_loop && (r_length != 7'd0)) begin
      r_length <= r_length - 7'd1;
      if (r_length == 7'd1) r_on <= 1'b0;
    end
  end

  volume_envelope u_envelope (
    .clk              (ac97_bitclk),
    .rst              (reset),
    .i_trigger        (w_trigger),
    .i_env_tick       (bus.env_tick),
    .i_initial_volume (bus.initial_volume),
    .i_increasing     (bus.envelope_increasing),
    .i_sweeps         (bus.num_envelope_sweeps),
    .o_volume         (w_volume)
  );

  always_ff @(posedge ac97_bitclk or posedge reset) begin
    if (reset) r_level <= 4'd0;
    else       r_level <= (r_on && !r_lfsr[0]) ? w_volume : 4'd0;
  end

  assign bus.level   = r_level;
  assign bus.on_flag = r_on;

`ifdef CH4_LFSR_OBSERVE_EN
  logic [LFSR_W-1:0] r_lfsr_obs;

  always_ff @(posedge ac97_bitclk or posedge reset) begin
    if (reset) r_lfsr_obs <= LFSR_SEED;
    else       r_lfsr_obs <= r_lfsr;
  end

  assign bus.lfsr_state = r_lfsr_obs;
`endif

endmodule

`default_nettype wire

// File: tb/tb_noise_channel.sv
// ============================================================================
// Module : tb_noise_channel
// Brief  : Directed self-checking bench for sound channel 4.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_noise_channel;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  logic [6:0] m7;
  logic       mx;

  noise_channel_if bus();

  noise_channel dut (
    .ac97_bitclk (clk),
    .reset       (rst),
    .bus         (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic trigger();
    bus.initialize = 1'b1;
    cyc();
    bus.initialize = 1'b0;
    cyc();
  endtask

  task automatic tick_base(input int n);
    for (int i = 0; i < n; i++) begin
      bus.base_tick = 1'b1;
      cyc();
      bus.base_tick = 1'b0;
      cyc();
    end
  endtask

  task automatic tick_length();
    bus.length_tick = 1'b1;
    cyc();
    bus.length_tick = 1'b0;
    cyc();
  endtask

  task automatic tick_env();
    bus.env_tick = 1'b1;
    cyc();
    bus.env_tick = 1'b0;
    cyc();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus.base_tick = 1'b0;
    bus.length_tick = 1'b0;
    bus.env_tick = 1'b0;
    bus.initialize = 1'b0;
    bus.length_data = 6'd0;
    bus.initial_volume = 4'hF;
    bus.envelope_increasing = 1'b0;
    bus.num_envelope_sweeps = 3'd0;
    bus.shift_clock_freq_data = 4'd0;
    bus.counter_width = 1'b0;
    bus.freq_dividing_ratio = 3'd0;
    bus.dont_loop = 1'b0;
    cyc(); cyc();
    check("reset_level", 16'(bus.level), 16'h0);
    check("reset_on", 16'(bus.on_flag), 16'h0);
    rst = 1'b0;
    cyc();

    // 15-bit LFSR: 7FFF -> ... -> 0001 keeps bit0 high for 14 shifts
    trigger();
    check("trig_on", 16'(bus.on_flag), 16'h1);
    check("trig_level", 16'(bus.level), 16'h0);
    tick_base(28);
    check("shift14_level", 16'(bus.level), 16'h0);
    tick_base(2);
    check("shift15_level", 16'(bus.level), 16'hF);
    tick_base(2);
    check("shift16_level", 16'(bus.level), 16'hF);
    tick_base(24);
    check("shift28_level", 16'(bus.level), 16'hF);

    // s=14 freezes at 0002, whose next shift would drop level
    bus.shift_clock_freq_data = 4'd14;
    bus.base_tick = 1'b1;
    repeat (2000) cyc();
    bus.base_tick = 1'b0;
    cyc();
    check("frozen_level", 16'(bus.level), 16'hF);
    bus.shift_clock_freq_data = 4'd0;
    tick_base(2);
    check("shift29_level", 16'(bus.level), 16'h0);
    tick_base(2);
    check("shift30_level", 16'(bus.level), 16'hF);

    rst = 1'b1;
    #1;
    check("midrst_level", 16'(bus.level), 16'h0);
    check("midrst_on", 16'(bus.on_flag), 16'h0);
    cyc();
    rst = 1'b0;
    cyc();

    // 7-bit mode: low seven bits form an independent 127-state sequence
    bus.counter_width = 1'b1;
    trigger();
    m7 = 7'h7F;
    for (int k = 1; k <= 137; k++) begin
      tick_base(2);
      mx = m7[0] ^ m7[1];
      m7 = {mx, m7[6:1]};
      if (k <= 10 || k >= 128)
        check($sformatf("w7_shift%0d", k), 16'(bus.level), m7[0] ? 16'h0 : 16'hF);
    end
    bus.counter_width = 1'b0;

    // Length counter 64-62 = 2
    bus.length_data = 6'd62;
    bus.dont_loop = 1'b1;
    trigger();
    check("len_on0", 16'(bus.on_flag), 16'h1);
    tick_length();
    check("len_on1", 16'(bus.on_flag), 16'h1);
    tick_length();
    check("len_on2", 16'(bus.on_flag), 16'h0);
    check("len_level2", 16'(bus.level), 16'h0);

    bus.dont_loop = 1'b0;
    trigger();
    for (int i = 0; i < 200; i++) tick_length();
    check("noloop_on", 16'(bus.on_flag), 16'h1);

    // Trigger wins over a coincident length_tick
    bus.dont_loop = 1'b1;
    bus.initialize = 1'b1;
    bus.length_tick = 1'b1;
    cyc();
    bus.initialize = 1'b0;
    bus.length_tick = 1'b0;
    cyc();
    check("coinc_on0", 16'(bus.on_flag), 16'h1);
    tick_length();
    check("coinc_on1", 16'(bus.on_flag), 16'h1);
    tick_length();
    check("coinc_on2", 16'(bus.on_flag), 16'h0);
    bus.dont_loop = 1'b0;

    // DAC off
    bus.initial_volume = 4'h0;
    bus.envelope_increasing = 1'b0;
    trigger();
    check("dacoff_on", 16'(bus.on_flag), 16'h0);
    check("dacoff_level", 16'(bus.level), 16'h0);

    // Decreasing envelope, one step per env_tick; LFSR parked at 4000
    bus.initial_volume = 4'hF;
    bus.num_envelope_sweeps = 3'd1;
    trigger();
    tick_base(30);
    check("envdn_start", 16'(bus.level), 16'hF);
    bus.shift_clock_freq_data = 4'd14;
    for (int v = 14; v >= 0; v--) begin
      tick_env();
      check($sformatf("envdn_%0d", v), 16'(bus.level), 16'(v));
    end
    tick_env();
    check("envdn_hold0", 16'(bus.on_flag), 16'h1);
    check("envdn_hold0_vol", 16'(bus.level), 16'h0);

    // Increasing envelope, step every 2 env_ticks, saturating at F
    bus.shift_clock_freq_data = 4'd0;
    bus.initial_volume = 4'hD;
    bus.envelope_increasing = 1'b1;
    bus.num_envelope_sweeps = 3'd2;
    trigger();
    tick_base(30);
    check("envup_start", 16'(bus.level), 16'hD);
    bus.shift_clock_freq_data = 4'd14;
    tick_env(); check("envup_1", 16'(bus.level), 16'hD);
    tick_env(); check("envup_2", 16'(bus.level), 16'hE);
    tick_env(); check("envup_3", 16'(bus.level), 16'hE);
    tick_env(); check("envup_4", 16'(bus.level), 16'hF);
    tick_env(); check("envup_5", 16'(bus.level), 16'hF);
    tick_env(); check("envup_6", 16'(bus.level), 16'hF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
